// File: rtl/bcd_ascii_tx.sv
// bcd_ascii_tx: serialises a captured 4-digit packed BCD word as decimal ASCII
// bytes plus a line terminator over a valid/ready byte handshake.
// Optional feature: define BCD_TX_LZS_EN for leading-zero suppression.
//
// state | meaning
// IDLE  | waiting for a bcd strobe, no byte presented
// DIGIT | presenting the digit selected by idx_q
// TERM1 | presenting CR (TERM_CRLF=1) or space (TERM_CRLF=0)
// TERM2 | presenting LF (TERM_CRLF=1 only)
module bcd_ascii_tx #(
  parameter bit          TERM_CRLF = 1'b1,
  parameter int unsigned DROP_SAT  = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        bcd_valid_i,
  input  logic [15:0] bcd_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  drop_cnt_o
);

  typedef enum logic [1:0] {IDLE, DIGIT, TERM1, TERM2} state_t;

  localparam logic [7:0] TERM1_BYTE = TERM_CRLF ? 8'h0D : 8'h20;
  localparam logic [7:0] DROP_MAX   = 8'(DROP_SAT);

  state_t      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic [7:0]  drop_q, drop_d;
  logic [1:0]  start_idx;
  logic        accept;
  logic        strobe_ok;

  function automatic logic [7:0] ascii_of(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] w, input logic [1:0] i);
    return w[{i, 2'b00} +: 4];
  endfunction

  // first digit to emit for the word being captured
  always_comb begin
`ifdef BCD_TX_LZS_EN
    if (bcd_i[15:12] != 4'h0)     start_idx = 2'd3;
    else if (bcd_i[11:8] != 4'h0) start_idx = 2'd2;
    else if (bcd_i[7:4] != 4'h0)  start_idx = 2'd1;
    else                          start_idx = 2'd0;
`else
    start_idx = 2'd3;
`endif
  end

  assign tx_valid_o = (state_q != IDLE);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign tx_data_o  = data_q;
  assign drop_cnt_o = drop_q;
  assign accept     = tx_valid_o && tx_ready_i;
  // the done cycle still counts as busy for incoming strobes
  assign strobe_ok  = bcd_valid_i && (state_q == IDLE) && !done_q;

  // next-state, next byte and drop counting
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = 1'b0;
    drop_d  = drop_q;
    if (bcd_valid_i && !strobe_ok && (drop_q != DROP_MAX)) drop_d = drop_q + 8'd1;
    case (state_q)
      IDLE: begin
        if (strobe_ok) begin
          hold_d  = bcd_i;
          idx_d   = start_idx;
          data_d  = ascii_of(nib(bcd_i, start_idx));
          state_d = DIGIT;
        end
      end
      DIGIT: begin
        if (accept) begin
          if (idx_q == 2'd0) begin
            state_d = TERM1;
            data_d  = TERM1_BYTE;
          end else begin
            idx_d  = idx_q - 2'd1;
            data_d = ascii_of(nib(hold_q, idx_q - 2'd1));
          end
        end
      end
      TERM1: begin
        if (accept) begin
          if (TERM_CRLF) begin
            state_d = TERM2;
            data_d  = 8'h0A;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      TERM2: begin
        if (accept) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      hold_q  <= 16'h0000;
      idx_q   <= 2'd0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      drop_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: doc/bcd_ascii_tx.md
# bcd_ascii_tx

Downstream stage of the 12-bit binary-to-BCD converter in the UART reporting path. Captures a 4-digit packed BCD word on its one-cycle valid strobe and serialises it as decimal ASCII bytes, followed by a line terminator, into the UART transmitter over a valid/ready byte handshake. Lets the Sobel/OV5640 pipeline print numeric values on a serial console without CPU involvement.

## Interface
- TERM_CRLF, 1, 1: terminator is CR (0x0D) then LF (0x0A); 0: single space (0x20)
- DROP_SAT, 255, saturation value of drop counter (≤255)
- clk  in  1  system clock
- nrst  in  1  reset, asynchronous, active-low
- bcd_valid  in  1  one-cycle strobe; bcd is valid this cycle
- bcd  in  16  packed BCD, digit 3 = bcd[15:12] … digit 0 = bcd[3:0]
- tx_data  out  8  ASCII byte to UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts byte when tx_valid & tx_ready
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last byte accepted
- drop_cnt  out  8  saturating count of strobes ignored while busy

## Operation
- Reset: all outputs 0; FSM in IDLE; drop_cnt = 0.
- States: IDLE, DIGIT, TERM1, TERM2.
- IDLE: on bcd_valid, latch bcd into holding register, set digit index to start index, go to DIGIT, busy = 1.
- Start index: 3 normally (see Configuration).
- DIGIT: tx_data = 0x30 + nibble[idx] for nibble 0–9; nibble 0xA–0xF sends 0x3F ('?'). On acceptance: if idx = 0 go to TERM1, else idx decrements.
- TERM1: tx_data = 0x0D if TERM_CRLF else 0x20. On acceptance: TERM2 if TERM_CRLF, else finish.
- TERM2: tx_data = 0x0A. On acceptance: finish.
- Finish: return to IDLE, busy = 0, done pulses high for one cycle.
- tx_valid = 1 in DIGIT/TERM1/TERM2; 0 in IDLE. tx_data is don't-care-but-stable (hold last) in IDLE.
- bcd_valid while busy (including the done cycle): frame ignored, drop_cnt increments, saturating at DROP_SAT. Held bcd register unaffected.
- drop_cnt cleared only by reset.
- Reset mid-frame: immediate return to IDLE, tx_valid = 0, partial frame abandoned, no done.

## Timing
- bcd_valid at cycle N → tx_valid = 1 with first byte at N+1.
- tx_data and tx_valid stay constant while tx_valid & !tx_ready (no change under back-pressure).
- Byte accepted at edge of cycle M → next byte presented in cycle M+1; with tx_ready tied high, one byte per cycle.
- Last byte accepted in cycle M → done = 1 and busy = 0 in cycle M+1; new bcd_valid accepted in cycle M+2 onward. A strobe in cycle M+1 counts as dropped.
- Frame length: digits sent + 2 (TERM_CRLF=1) or + 1 (TERM_CRLF=0).

## Configuration
- Macro BCD_TX_LZS_EN (leading-zero suppression).
- Defined: at capture, start index = highest nonzero digit among 3..1, else 0; leading '0' bytes never emitted, digit 0 always emitted (value 0 → "0"). Suppression costs no cycles; first byte still at N+1. Nibbles > 9 count as nonzero.
- Undefined: start index always 3; exactly 4 digit bytes per frame.

## Test plan
- bcd = 0x1234, tx_ready = 1, TERM_CRLF = 1 → bytes 0x31,0x32,0x33,0x34,0x0D,0x0A on 6 consecutive cycles starting N+1; done at N+7.
- bcd = 0x0007: with BCD_TX_LZS_EN → 0x37,0x0D,0x0A; without → 0x30,0x30,0x30,0x37,0x0D,0x0A; bcd = 0x0000 with macro → 0x30,0x0D,0x0A.
- bcd = 0x4095, tx_ready low for 5 cycles after each byte presented → each byte held stable on tx_data for 6 cycles, sequence 0x34,0x30,0x39,0x35,0x0D,0x0A intact.
- Three bcd_valid strobes during a frame, one on the done cycle → drop_cnt = 3, emitted frame unchanged; 300 such strobes → drop_cnt = 255.
- bcd = 0x12A4 → 0x31,0x32,0x3F,0x34,CR,LF; TERM_CRLF = 0 → frame ends with single 0x20.
- nrst asserted after second byte accepted → tx_valid, busy, done, drop_cnt = 0 immediately; next bcd_valid starts a full fresh frame.
